// File: rtl/ras_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package     : ras_pkg
// Description : Shared widths, FSM encoding and helpers for reg_access_seq.
// Revision    : 1.0 - initial release
// ============================================================================
package ras_pkg;

    localparam int REG_SEL_W = 4;
    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_READ  = 2'd2,
        ST_HOLD  = 2'd3
    } ras_state_e;

    function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [REG_SEL_W-1:0] sel);
        return NUM_REGS'(1) << sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ras_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ras_scoreboard
// Description : One pending bit per register; a set on the same edge as a
//               clear of the same register leaves the bit set.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_scoreboard
    import ras_pkg::*;
(
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 i_set_en,
    input  logic [REG_SEL_W-1:0] i_set_sel,
    input  logic                 i_clr_en,
    input  logic [REG_SEL_W-1:0] i_clr_sel,
    output logic [NUM_REGS-1:0]  o_pending
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;

    assign w_set_mask = i_set_en ? sel_onehot(i_set_sel) : '0;
    assign w_clr_mask = i_clr_en ? sel_onehot(i_clr_sel) : '0;

    // Clear applied first so a coincident set wins.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/reg_access_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : reg_access_seq
// Description : Register-access sequencer: accepts a decoded instruction,
//               reads its two source operands and presents them to execute,
//               while driving the register-file write port from writeback.
//               Define REG_ACCESS_SEQ_HAZARD_EN to add the RAW scoreboard and
//               STALL handling.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_access_seq
    import ras_pkg::*;
(
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [REG_SEL_W-1:0] IN_RN,
    input  logic [REG_SEL_W-1:0] IN_RM,
    input  logic [REG_SEL_W-1:0] IN_RD,
    input  logic                 IN_WB,
    output logic [REG_SEL_W-1:0] RA,
    output logic [REG_SEL_W-1:0] RB,
    input  logic [DATA_W-1:0]    RF_A,
    input  logic [DATA_W-1:0]    RF_B,
    output logic [REG_SEL_W-1:0] RC,
    output logic                 RFE,
    input  logic                 WB_VALID,
    input  logic [REG_SEL_W-1:0] WB_RD,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [DATA_W-1:0]    OUT_OPA,
    output logic [DATA_W-1:0]    OUT_OPB,
    output logic [REG_SEL_W-1:0] OUT_RD,
    output logic                 OUT_WB,
    output logic                 BUSY
);

    ras_state_e           r_state;
    ras_state_e           w_state_nxt;

    logic [REG_SEL_W-1:0] r_rn;
    logic [REG_SEL_W-1:0] r_rm;
    logic [REG_SEL_W-1:0] r_rd;
    logic                 r_wb;

    logic [DATA_W-1:0]    r_opa;
    logic [DATA_W-1:0]    r_opb;
    logic [REG_SEL_W-1:0] r_out_rd;
    logic                 r_out_wb;

    logic [REG_SEL_W-1:0] r_rc;
    logic                 r_rfe;

    logic                 w_accept;
    logic                 w_read_exit;
    logic                 w_hazard;
    logic                 w_srcs_clear;

    assign w_accept    = (r_state == ST_IDLE) & IN_VALID;
    assign w_read_exit = (r_state == ST_READ);

`ifdef REG_ACCESS_SEQ_HAZARD_EN
    logic [NUM_REGS-1:0]  w_pending;

    ras_scoreboard u_scoreboard (
        .CLK       (CLK),
        .CLR       (CLR),
        .i_set_en  (w_read_exit & r_wb),
        .i_set_sel (r_rd),
        .i_clr_en  (WB_VALID),
        .i_clr_sel (WB_RD),
        .o_pending (w_pending)
    );

    // Hazard decisions look only at the registered pending bits.
    assign w_hazard     = w_pending[IN_RN] | w_pending[IN_RM];
    assign w_srcs_clear = ~(w_pending[r_rn] | w_pending[r_rm]);
`else
    assign w_hazard     = 1'b0;
    assign w_srcs_clear = 1'b1;
`endif

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        IN_READY    = 1'b0;
        OUT_VALID   = 1'b0;
        BUSY        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                IN_READY = 1'b1;
                BUSY     = 1'b0;
                if (IN_VALID) begin
                    w_state_nxt = w_hazard ? ST_STALL : ST_READ;
                end
            end
            ST_STALL: begin
                if (w_srcs_clear) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_rn <= '0;
            r_rm <= '0;
            r_rd <= '0;
            r_wb <= 1'b0;
        end else if (w_accept) begin
            r_rn <= IN_RN;
            r_rm <= IN_RM;
            r_rd <= IN_RD;
            r_wb <= IN_WB;
        end
    end

    // Operands are captured as READ exits and held through HOLD.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_out_rd <= '0;
            r_out_wb <= 1'b0;
        end else if (w_read_exit) begin
            r_opa    <= RF_A;
            r_opb    <= RF_B;
            r_out_rd <= r_rd;
            r_out_wb <= r_wb;
        end
    end

    // Write port runs independently of the instruction FSM.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_rc  <= '0;
            r_rfe <= 1'b1;
        end else begin
            r_rfe <= ~WB_VALID;
            if (WB_VALID) begin
                r_rc <= WB_RD;
            end
        end
    end

    assign RA      = r_rn;
    assign RB      = r_rm;
    assign RC      = r_rc;
    assign RFE     = r_rfe;
    assign OUT_OPA = r_opa;
    assign OUT_OPB = r_opb;
    assign OUT_RD  = r_out_rd;
    assign OUT_WB  = r_out_wb;

endmodule
`default_nettype wire
